// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types and constants used by the fetch front-end.
package rv32i_types;

  typedef enum logic [1:0] {
    RESET    = 2'd0,
    FETCH    = 2'd1,
    BUFFERED = 2'd2,
    FLUSH    = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RV32I_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0060;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, inst} holding register; parks a fetched instruction while ID stalls.
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // clear wins over load so a redirect can never leave a stale entry behind
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      inst  <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage front-end: owns the fetch PC, the instruction-cache handshake and the IF/ID register.
// Cache handshake: inst_read/inst_addr stay constant from request until the inst_resp pulse.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = RV32I_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_addr,
  output logic        inst_read,
  input  logic [31:0] inst_rdata,
  input  logic        inst_resp,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [1:0]  dbg_state
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  flush_addr;
  logic         ifid_valid;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_inst;

  logic         buf_load;
  logic         buf_clear;
  logic         buf_valid;
  logic [31:0]  buf_pc;
  logic [31:0]  buf_inst;
  logic [31:0]  redirect_target;

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  if_skid_buffer u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_pc   (fetch_pc),
    .load_inst (inst_rdata),
    .valid     (buf_valid),
    .pc        (buf_pc),
    .inst      (buf_inst)
  );

  always_comb begin
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (state != RESET && redirect)
      buf_clear = 1'b1;
    else if (state == FETCH && inst_resp && stall && ifid_valid)
      buf_load = 1'b1;
    else if (state == BUFFERED && !stall)
      buf_clear = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RESET;
      fetch_pc   <= RESET_PC;
      flush_addr <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'h0;
      ifid_inst  <= NOP_INST;
    end else begin
      case (state)
        RESET: state <= FETCH;
        FETCH: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            fetch_pc   <= redirect_target;
            // request still outstanding: keep its address on the bus until it returns
            if (!inst_resp) begin
              state      <= FLUSH;
              flush_addr <= fetch_pc;
            end
          end else if (inst_resp) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (!stall || !ifid_valid) begin
              ifid_valid <= 1'b1;
              ifid_pc    <= fetch_pc;
              ifid_inst  <= inst_rdata;
            end else begin
              state <= BUFFERED;
            end
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            fetch_pc   <= redirect_target;
            state      <= FETCH;
          end else if (!stall) begin
            ifid_valid <= buf_valid;
            ifid_pc    <= buf_pc;
            ifid_inst  <= buf_inst;
            state      <= FETCH;
          end
        end
        FLUSH: begin
          if (redirect) begin
            ifid_valid <= 1'b0;
            fetch_pc   <= redirect_target;
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
          if (inst_resp) state <= FETCH;
        end
        default: state <= RESET;
      endcase
    end
  end

  assign inst_read = (state == FLUSH) || (state == FETCH && !buf_valid);
  assign inst_addr = (state == FLUSH) ? flush_addr : fetch_pc;
  assign if_valid  = ifid_valid;
  assign if_pc     = ifid_pc;
  assign if_inst   = ifid_valid ? ifid_inst : NOP_INST;
  assign dbg_state = state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage front-end between the pipelined RV32I datapath's IF/ID boundary and the instruction cache port.
- Owns the fetch PC and the inst_read/inst_addr/inst_resp handshake.
- Holds one fetched instruction across ID-stage stalls using a one-entry skid buffer.
- Applies branch/jump redirects from the MEM stage, including squashing a request already in flight.

Parameters:
- RESET_PC, 32'h0000_0060, first fetch address after reset.
- NOP_INST, 32'h0000_0013, value driven on if_inst when if_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  ID stage cannot accept; the IF/ID output must hold.
- redirect  in  1  taken branch/jump resolved in MEM; single-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.
- inst_addr  out  32  instruction cache address.
- inst_read  out  1  instruction cache read request.
- inst_rdata  in  32  instruction cache read data; valid when inst_resp=1.
- inst_resp  in  1  instruction cache response; single-cycle pulse; may assert in the same cycle inst_read rises.
- if_valid  out  1  IF/ID holds a live instruction.
- if_pc  out  32  PC of if_inst.
- if_inst  out  32  fetched instruction, or NOP_INST when invalid.

Behaviour:
- Reset (rst=0, async):
  - state=RESET; fetch_pc=RESET_PC; buf_valid=0.
  - if_valid=0; if_pc=0; if_inst=NOP_INST.
  - inst_read=0; inst_addr=RESET_PC.
- States: RESET, FETCH, BUFFERED, FLUSH.
  - RESET: inst_read=0. Moves to FETCH one cycle after rst deasserts.
  - FETCH: inst_read=1, inst_addr=fetch_pc. On inst_resp:
    - if stall=0 or if_valid=0: load IF/ID with {fetch_pc, inst_rdata}, if_valid=1.
    - otherwise: load buffer with {fetch_pc, inst_rdata}, go to BUFFERED.
    - in both cases fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - BUFFERED: inst_read=0. When stall=0: IF/ID <= buffer, buf_valid=0, go to FETCH.
  - FLUSH: inst_read=1 with the stale address held. On inst_resp: discard the data, go to FETCH.
- IF/ID consumption: when stall=0 and no new data is loaded this cycle, if_valid <= 0.
- Throughput: one instruction per cycle when inst_resp returns in the request cycle and stall=0.
- Address stability: inst_addr and inst_read must not change while a request is outstanding (inst_read=1 and no inst_resp yet).
- Redirect (highest priority, overrides stall):
  - if_valid <= 0, buf_valid <= 0, fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - In FETCH with no inst_resp that cycle: go to FLUSH, because the request is outstanding.
  - In FETCH with inst_resp that cycle: discard the response, stay in FETCH.
  - In BUFFERED: go to FETCH.
  - In FLUSH: update fetch_pc; if inst_resp arrives that cycle go to FETCH, else stay in FLUSH.
  - In RESET: ignored.
- Simultaneous stall and redirect: a bubble is produced (if_valid=0) and the redirect wins.
- The buffer holds at most one instruction; no request is issued while buf_valid=1.
- if_inst=NOP_INST whenever if_valid=0.

Decomposition:
- Shared package (added to rv32i_types):
  - fetch_state_t enum {RESET, FETCH, BUFFERED, FLUSH}.
  - NOP constant 32'h0000_0013.
  - RESET_PC default constant.
- Sub-module: if_skid_buffer, a one-entry {pc, inst} holding register with load/clear/valid.
  - Instantiated for the buffer only.
  - The IF/ID output register stays in fetch_unit.

Test Plan:
- Reset release, inst_resp tied high, stall=0 -> inst_addr sequence 0x60, 0x64, 0x68; if_pc follows one cycle behind; if_valid=1 from the second cycle after reset release.
- Cache latency 3 cycles -> inst_addr held at 0x64 for all 3 cycles with inst_read=1; if_valid pulses once per response; no duplicate PCs.
- stall=1 for 4 cycles while responses arrive:
  - if_pc stays at 0x64; instruction 0x68 is buffered and inst_read=0.
  - After stall drops: if_pc=0x68 next, then a fetch of 0x6C is issued.
- redirect to 0x200 with a request for 0x70 outstanding (latency 2):
  - inst_addr stays 0x70 until inst_resp; the 0x70 data is never presented (if_valid=0).
  - Next request is 0x200, then if_pc=0x200.
- redirect_pc=0x203 together with stall=1 and buffer full -> if_valid=0 next cycle; buffer cleared; next fetch address 0x200.
- Async reset asserted mid-FLUSH -> all outputs immediately at reset values; after release the fetch restarts at 0x60.
